// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one imem read in flight,
// and buffers fetched words in a 2-entry FIFO that feeds decode.
module fetch_unit #(
    parameter int            AW       = 7,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    output logic [DW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
    input  logic          inst_ready,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] stale_q, stale_d;
    logic [1:0]    count_q, count_d, count_pp;
    logic          head_q, head_d;
    logic          tail;
    logic [AW-1:0] fifo_pc_q   [2];
    logic [DW-1:0] fifo_data_q [2];
    logic [AW-1:0] redir_pc;
    logic          push, pop;
    logic          unused_redirect_lsb;

    // Transfers happen on a rising edge where both sides of a pair are high:
    // imem_req & imem_ack moves one word in, inst_valid & inst_ready moves one out.
    assign redir_pc            = {redirect_pc[AW-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign push     = (state_q == S_WAIT) && imem_ack && !redirect;
    assign pop      = inst_valid && inst_ready && !redirect;
    assign count_pp = count_q + {1'b0, push} - {1'b0, pop};
    assign count_d  = redirect ? 2'd0 : count_pp;
    assign head_d   = pop ? ~head_q : head_q;
    assign tail     = head_q ^ count_q[0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    state_d = S_WAIT;
                    pc_d    = redir_pc;
                end else if (count_q < 2'd2) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redir_pc;
                    // An unacknowledged read cannot be withdrawn, so wait it out.
                    if (!imem_ack) begin
                        state_d = S_FLUSH;
                        stale_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_q + AW'(4);
                    if (count_pp == 2'd2) state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (redirect) pc_d = redir_pc;
                if (imem_ack) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            stale_q <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_pc_q[0]   <= '0;
            fifo_pc_q[1]   <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
        end else if (push) begin
            fifo_pc_q[tail]   <= pc_q;
            fifo_data_q[tail] <= imem_rdata;
        end
    end

    assign imem_req    = (state_q != S_IDLE);
    assign imem_addr   = (state_q == S_FLUSH) ? stale_q : pc_q;
    assign inst_valid  = (count_q != 2'd0);
    assign inst_pc     = fifo_pc_q[head_q];
    assign inst_data   = fifo_data_q[head_q];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based model of the fetch front end checked against
// the DUT every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;
    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int mem_wait = 0;

    fetch_unit #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
        return 32'h1000_0000 | {25'b0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory responder: ack after mem_wait stall cycles ----------------
    initial begin : memory
        int  cnt;
        bit  last_req;
        cnt      = 0;
        last_req = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            tick();
            if (!rst) begin
                cnt      = 0;
                imem_ack = 1'b0;
                last_req = 0;
            end else begin
                if (last_req && !imem_ack && imem_req) cnt++;
                else cnt = 0;
                imem_ack   = imem_req && (cnt >= mem_wait);
                imem_rdata = mk(imem_addr);
                last_req   = imem_req;
            end
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    bit            m_req        = 0;
    bit            m_stale      = 0;
    logic [AW-1:0] m_pc         = '0;
    logic [AW-1:0] m_stale_addr = '0;

    always @(posedge clk or negedge rst) begin : model
        bit   ack_m;
        int   pre;
        ent_t e;
        if (!rst) begin
            m_q.delete();
            m_req   = 0;
            m_stale = 0;
            m_pc    = '0;
        end else begin
            ack_m = m_req && imem_ack;
            pre   = m_q.size();
            if (redirect) begin
                m_q.delete();
                if (m_req && !ack_m) begin
                    if (!m_stale) m_stale_addr = m_pc;
                    m_stale = 1;
                end else begin
                    m_stale = 0;
                end
                m_req = 1;
                m_pc  = {redirect_pc[AW-1:2], 2'b00};
            end else begin
                if (inst_ready && pre > 0) void'(m_q.pop_front());
                if (ack_m) begin
                    if (m_stale) begin
                        m_stale = 0;
                    end else begin
                        e.pc   = m_pc;
                        e.data = imem_rdata;
                        m_q.push_back(e);
                        m_pc  = m_pc + 7'd4;
                        m_req = (m_q.size() < 2);
                    end
                end else if (!m_req && pre < 2) begin
                    m_req = 1;
                end
            end
        end
    end

    // ---------------- per-cycle scoreboard compare ----------------
    always @(negedge clk) begin
        chk("cyc_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("cyc_addr", {25'b0, imem_addr}, {25'b0, (m_stale ? m_stale_addr : m_pc)});
        chk("cyc_valid", {31'b0, inst_valid}, {31'b0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            chk("cyc_inst_pc", {25'b0, inst_pc}, {25'b0, m_q[0].pc});
            chk("cyc_inst_data", inst_data, m_q[0].data);
        end
    end

    // ---------------- consumption log from the DUT ----------------
    int            cyc = 0;
    logic [AW-1:0] log_pc[$];
    int            log_cyc[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && inst_valid && inst_ready && !redirect) begin
            log_pc.push_back(inst_pc);
            log_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        log_pc.delete();
        log_cyc.delete();
    endtask

    task automatic chk_log(input string name, input int i, input logic [AW-1:0] exp);
        if (i < log_pc.size()) chk(name, {25'b0, log_pc[i]}, {25'b0, exp});
        else chk(name, 32'hFFFF_FFFF, {25'b0, exp});
    endtask

    task automatic count_in_log(input string name, input logic [AW-1:0] pc);
        int n;
        n = 0;
        foreach (log_pc[i]) if (log_pc[i] == pc) n++;
        chk(name, n, 0);
    endtask

    task automatic wait_addr(input string name, input logic [AW-1:0] a);
        int n;
        n = 0;
        while (!(imem_req && imem_addr == a) && n < 50) begin
            tick();
            n++;
        end
        chk(name, {31'b0, (imem_req && imem_addr == a)}, 32'd1);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_log();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        mem_wait    = 0;
        repeat (3) tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", {25'b0, imem_addr}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst_pc", {25'b0, inst_pc}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);

        // Zero-wait streaming with wrap-around.
        rst = 1'b1;
        clear_log();
        tick();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", {25'b0, imem_addr}, 32'd0);
        repeat (39) tick();
        for (int i = 0; i < 34; i++) begin
            chk_log("stream_pc", i, AW'((i * 4) % 128));
            if (i < log_cyc.size()) chk("stream_cyc", log_cyc[i] - log_cyc[0], i);
        end
        chk_log("stream_pc_124", 31, 7'd124);
        chk_log("stream_pc_wrap", 32, 7'd0);

        // Reset dropped mid-request at address 8.
        do_reset();
        wait_addr("mid_wait8", 7'd8);
        #3 rst = 1'b0;
        #1;
        chk("mid_req", {31'b0, imem_req}, 32'd0);
        chk("mid_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_inst_pc", {25'b0, inst_pc}, 32'd0);
        chk("mid_addr", {25'b0, imem_addr}, 32'd0);
        chk("mid_data", inst_data, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rel_req", {31'b0, imem_req}, 32'd1);
        chk("mid_rel_addr", {25'b0, imem_addr}, 32'd0);

        // Backpressure: two words buffered then drained in order.
        inst_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("bp_req", {31'b0, imem_req}, 32'd0);
        chk("bp_addr", {25'b0, imem_addr}, 32'd8);
        chk("bp_valid", {31'b0, inst_valid}, 32'd1);
        chk("bp_inst_pc", {25'b0, inst_pc}, 32'd0);
        chk("bp_inst_data", inst_data, mk(7'd0));
        inst_ready = 1'b1;
        repeat (10) tick();
        chk_log("bp_pc0", 0, 7'd0);
        chk_log("bp_pc1", 1, 7'd4);
        chk_log("bp_pc2", 2, 7'd8);
        chk_log("bp_pc3", 3, 7'd12);

        // Redirect while the read of 12 is stalled; low bits of target ignored.
        mem_wait = 3;
        do_reset();
        wait_addr("rd_wait12", 7'd12);
        redirect    = 1'b1;
        redirect_pc = 7'd42;
        clear_log();
        tick();
        redirect = 1'b0;
        chk("rd_hold_req", {31'b0, imem_req}, 32'd1);
        chk("rd_hold_addr", {25'b0, imem_addr}, 32'd12);
        chk("rd_hold_valid", {31'b0, inst_valid}, 32'd0);
        wait_addr("rd_wait40", 7'd40);
        repeat (20) tick();
        chk_log("rd_first_pc", 0, 7'd40);
        chk_log("rd_second_pc", 1, 7'd44);
        count_in_log("rd_no_stale12", 7'd12);

        // A second redirect during the flush wins.
        do_reset();
        wait_addr("fl_wait8", 7'd8);
        redirect    = 1'b1;
        redirect_pc = 7'd40;
        clear_log();
        tick();
        redirect_pc = 7'd64;
        tick();
        redirect = 1'b0;
        wait_addr("fl_wait64", 7'd64);
        repeat (20) tick();
        chk_log("fl_first_pc", 0, 7'd64);
        count_in_log("fl_no_40", 7'd40);

        // Redirect on the same edge as an ack and a pop with one word buffered.
        mem_wait = 0;
        do_reset();
        repeat (6) tick();
        redirect    = 1'b1;
        redirect_pc = 7'd40;
        clear_log();
        tick();
        redirect = 1'b0;
        chk("same_valid", {31'b0, inst_valid}, 32'd0);
        chk("same_req", {31'b0, imem_req}, 32'd1);
        chk("same_addr", {25'b0, imem_addr}, 32'd40);
        repeat (6) tick();
        chk_log("same_first_pc", 0, 7'd40);

        // Redirect while idle with a full buffer.
        inst_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        redirect    = 1'b1;
        redirect_pc = 7'd100;
        tick();
        redirect   = 1'b0;
        inst_ready = 1'b1;
        chk("idle_rd_valid", {31'b0, inst_valid}, 32'd0);
        chk("idle_rd_req", {31'b0, imem_req}, 32'd1);
        chk("idle_rd_addr", {25'b0, imem_addr}, 32'd100);
        repeat (6) tick();
        chk_log("idle_rd_pc", 0, 7'd100);

        // Two wait states: one instruction every three cycles.
        mem_wait = 2;
        do_reset();
        repeat (14) tick();
        chk_log("ws_pc0", 0, 7'd0);
        chk_log("ws_pc1", 1, 7'd4);
        chk_log("ws_pc2", 2, 7'd8);
        if (log_cyc.size() >= 3) begin
            chk("ws_gap1", log_cyc[1] - log_cyc[0], 3);
            chk("ws_gap2", log_cyc[2] - log_cyc[1], 3);
        end else begin
            chk("ws_count", log_cyc.size(), 3);
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RISC-V datapath. It owns the fetch program counter and reads instruction memory through a req/ack handshake, one request outstanding at a time. Fetched words go into a 2-entry buffer and are handed to decode over a valid/ready interface. Branch/jump redirects from execute flush the buffer and discard any stale in-flight read.

## Interface
- AW, 7: byte address width; PC steps by 4 and wraps modulo 2^AW.
- DW, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  AW  read address; stable while imem_req high and unacknowledged.
- imem_ack  in  1  memory accepted the request; imem_rdata valid this cycle; only meaningful while imem_req high.
- imem_rdata  in  DW  instruction word qualified by imem_ack.
- redirect  in  1  single-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  AW  new fetch address; low 2 bits ignored (treated as 0).
- inst_valid  out  1  buffer head holds an instruction.
- inst_data  out  DW  instruction at buffer head.
- inst_pc  out  AW  address of inst_data.
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready.

## Operation
- Registers: pc (AW), state, 2-entry FIFO of {pc, data}, count (0..2).
- imem_req = (state != IDLE); imem_addr = pc in WAIT; in FLUSH, the address of the stale request (held in a separate register).
- inst_valid = (count != 0); inst_data/inst_pc come from the FIFO head directly, with no extra output register.
- States:
  - IDLE: no request. Go to WAIT when count < 2 at the edge, or immediately on redirect.
  - WAIT: request pc. On ack, push {pc, imem_rdata} and set pc = pc + 4. Stay in WAIT if the post-push/pop count < 2, else go to IDLE.
  - FLUSH: stale request outstanding; address held. On ack, discard data and go to WAIT at the stored redirect pc.
- Redirect (highest priority):
  - Always: FIFO cleared (count = 0); the pop that cycle is ignored; pc = redirect_pc.
  - In WAIT without ack: go to FLUSH, latching the stale address.
  - In WAIT with ack the same cycle: data is discarded and the next state is WAIT at the new pc.
  - In FLUSH: pc is updated to the newest redirect_pc; stay in FLUSH until ack.
  - In IDLE: go to WAIT.
- Push and pop in the same cycle leave count unchanged. The FIFO never overflows because a request is issued only when count < 2 and there is only one outstanding request.
- Wrap-around: with AW = 7, pc goes 124 -> 0, with no error.
- rst low (any time, including mid-request): state = IDLE, pc = RESET_PC, count = 0, FIFO storage = 0. Outputs take their reset values immediately. Memory must abandon an unacknowledged request when rst is asserted.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0.
- First rising edge after rst release: IDLE -> WAIT. imem_req = 1 with imem_addr = RESET_PC from that cycle on.
- Ack sampled at edge k -> inst_valid = 1 with that word from edge k (same cycle the next address appears).
- Zero-wait memory (ack whenever req) with inst_ready = 1 sustains 1 instruction/cycle.
- N memory wait cycles per access give 1 instruction per N+1 cycles.
- After a redirect at edge r:
  - inst_valid = 0 from edge r.
  - New-address request visible from edge r if no request was outstanding or ack coincided with r.
  - Otherwise the new-address request is visible one cycle after the stale ack.

## Test plan
- Reset mid-fetch: drop rst while imem_req = 1 at addr 8 -> imem_req, inst_valid, inst_pc go to 0 immediately. After release, req at addr 0 one edge later.
- Streaming with zero-wait memory, inst_ready = 1 (rdata = addr) -> inst_pc 0, 4, 8 … 124, 0 on consecutive cycles; inst_data matches inst_pc.
- Backpressure: inst_ready = 0 -> exactly 2 words (0, 4) buffered, imem_req low, imem_addr 8. Raise inst_ready -> drains 0, 4; fetch resumes at 8 with no gap or duplicate.
- Redirect to 40 while addr 12 awaits ack delayed 3 cycles -> imem_addr holds 12 until ack, 12's data is never presented, next request addr 40, first inst_pc 40.
- Redirect to 40 on the same edge as ack and pop, with count = 1 -> both words dropped, inst_valid 0 next cycle, next request addr 40.
- 2-wait-state memory -> inst_valid pulses every 3 cycles, in-order addresses 0, 4, 8; no request issued while count = 2.
